// File: rtl/sc_regshift_datapath.sv
// Pattern register and shifter that executes the game state machine's active-low commands.
// Optional build macro SC_REGSHIFT_WRAP_EN makes shifts rotate instead of blocking at the edges.
module sc_regshift_datapath #(
    parameter int                       DATAWIDTH_BUS = 8,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_LOAD0    = DATAWIDTH_BUS'(8'h18),
    parameter logic [DATAWIDTH_BUS-1:0] DATA_LOAD1    = DATAWIDTH_BUS'(8'h01)
) (
    input  logic                     SC_STATEMACHINE_GENERAL_CLOCK_50,
    input  logic                     SC_STATEMACHINE_GENERAL_RESET_InHigh,
    input  logic                     clear_InLow,
    input  logic                     load0_InLow,
    input  logic                     load1_InLow,
    input  logic [1:0]               shiftselection_In,
    output logic [DATAWIDTH_BUS-1:0] data_Out,
    output logic                     bottomsidecomparator_OutLow,
    output logic                     topsidecomparator_OutLow,
    output logic                     ack_OutLow,
    output logic                     blocked_OutLow,
    output logic [7:0]               movecount_Out
);

    localparam int MSB = DATAWIDTH_BUS - 1;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_EXEC = 1'b1;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    logic [DATAWIDTH_BUS-1:0] data_r;
    logic [DATAWIDTH_BUS-1:0] dataNext_s;
    logic [7:0]               moveCount_r;
    logic [7:0]               moveCountNext_s;
    logic [0:0]               state_r;
    logic [0:0]               stateNext_s;
    logic                     exec_s;
    logic                     bottomLow_r;
    logic                     topLow_r;
`ifndef SC_REGSHIFT_WRAP_EN
    logic                     blocked_s;
    logic                     blockedLow_r;
`endif

    function automatic logic [DATAWIDTH_BUS-1:0] shiftLeft(input logic [DATAWIDTH_BUS-1:0] d);
`ifdef SC_REGSHIFT_WRAP_EN
        return {d[MSB-1:0], d[MSB]};
`else
        return {d[MSB-1:0], 1'b0};
`endif
    endfunction

    function automatic logic [DATAWIDTH_BUS-1:0] shiftRight(input logic [DATAWIDTH_BUS-1:0] d);
`ifdef SC_REGSHIFT_WRAP_EN
        return {d[0], d[MSB:1]};
`else
        return {1'b0, d[MSB:1]};
`endif
    endfunction

    function automatic logic [7:0] satIncrement(input logic [7:0] c);
        if (c == 8'hFF) begin
            return c;
        end else begin
            return c + 8'd1;
        end
    endfunction

    // Command decode: priority clear > load0 > load1 > shift > hold.
    always_comb begin
        dataNext_s      = data_r;
        moveCountNext_s = moveCount_r;
        exec_s          = 1'b0;
`ifndef SC_REGSHIFT_WRAP_EN
        blocked_s       = 1'b0;
`endif
        if (!clear_InLow) begin
            dataNext_s      = '0;
            moveCountNext_s = 8'd0;
            exec_s          = 1'b1;
        end else if (!load0_InLow) begin
            dataNext_s = DATA_LOAD0;
            exec_s     = 1'b1;
        end else if (!load1_InLow) begin
            dataNext_s = DATA_LOAD1;
            exec_s     = 1'b1;
        end else begin
            case (shiftselection_In)
                SHIFT_LEFT: begin
                    exec_s = 1'b1;
`ifdef SC_REGSHIFT_WRAP_EN
                    dataNext_s      = shiftLeft(data_r);
                    moveCountNext_s = satIncrement(moveCount_r);
`else
                    if (data_r[MSB]) begin
                        blocked_s = 1'b1;
                    end else begin
                        dataNext_s      = shiftLeft(data_r);
                        moveCountNext_s = satIncrement(moveCount_r);
                    end
`endif
                end
                SHIFT_RIGHT: begin
                    exec_s = 1'b1;
`ifdef SC_REGSHIFT_WRAP_EN
                    dataNext_s      = shiftRight(data_r);
                    moveCountNext_s = satIncrement(moveCount_r);
`else
                    if (data_r[0]) begin
                        blocked_s = 1'b1;
                    end else begin
                        dataNext_s      = shiftRight(data_r);
                        moveCountNext_s = satIncrement(moveCount_r);
                    end
`endif
                end
                default: begin
                    dataNext_s = data_r;
                end
            endcase
        end
    end

    // Control state: EXEC for every cycle in which a command was executed.
    always_comb begin
        if (exec_s) begin
            stateNext_s = STATE_EXEC;
        end else begin
            stateNext_s = STATE_IDLE;
        end
    end

    // Datapath, status and comparator registers; comparators decode the next data so they track data_Out.
    always_ff @(posedge SC_STATEMACHINE_GENERAL_CLOCK_50 or posedge SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
            data_r       <= '0;
            moveCount_r  <= 8'd0;
            state_r      <= STATE_IDLE;
            bottomLow_r  <= 1'b1;
            topLow_r     <= 1'b1;
`ifndef SC_REGSHIFT_WRAP_EN
            blockedLow_r <= 1'b1;
`endif
        end else begin
            data_r       <= dataNext_s;
            moveCount_r  <= moveCountNext_s;
            state_r      <= stateNext_s;
            bottomLow_r  <= ~dataNext_s[0];
            topLow_r     <= ~dataNext_s[MSB];
`ifndef SC_REGSHIFT_WRAP_EN
            blockedLow_r <= ~blocked_s;
`endif
        end
    end

    assign data_Out                    = data_r;
    assign movecount_Out               = moveCount_r;
    assign ack_OutLow                  = (state_r == STATE_EXEC) ? 1'b0 : 1'b1;
    assign bottomsidecomparator_OutLow = bottomLow_r;
    assign topsidecomparator_OutLow    = topLow_r;
`ifdef SC_REGSHIFT_WRAP_EN
    assign blocked_OutLow              = 1'b1;
`else
    assign blocked_OutLow              = blockedLow_r;
`endif

endmodule

// File: tb/tb_sc_regshift_datapath.sv
// Self-checking bench for sc_regshift_datapath with an arithmetic reference model.
// Follows SC_REGSHIFT_WRAP_EN to select rotate or edge-blocking expectations.
module tb_sc_regshift_datapath;

    logic       clk;
    logic       rst;
    logic       clearLow;
    logic       load0Low;
    logic       load1Low;
    logic [1:0] shiftSel;
    logic [7:0] dataOut;
    logic       bottomLow;
    logic       topLow;
    logic       ackLow;
    logic       blockedLow;
    logic [7:0] moveCount;

    int total = 0;
    int bad   = 0;

    // Model state: plain integers updated from the command rules
    int mData = 0;
    int mMove = 0;
    int mAck  = 1;
    int mBlk  = 1;

    sc_regshift_datapath dut (
        .SC_STATEMACHINE_GENERAL_CLOCK_50    (clk),
        .SC_STATEMACHINE_GENERAL_RESET_InHigh(rst),
        .clear_InLow                         (clearLow),
        .load0_InLow                         (load0Low),
        .load1_InLow                         (load1Low),
        .shiftselection_In                   (shiftSel),
        .data_Out                            (dataOut),
        .bottomsidecomparator_OutLow         (bottomLow),
        .topsidecomparator_OutLow            (topLow),
        .ack_OutLow                          (ackLow),
        .blocked_OutLow                      (blockedLow),
        .movecount_Out                       (moveCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, "_data"},    dataOut,    8'(mData));
        check({tag, "_move"},    moveCount,  8'(mMove));
        check({tag, "_ack"},     {7'd0, ackLow},     8'(mAck));
        check({tag, "_blocked"}, {7'd0, blockedLow}, 8'(mBlk));
        check({tag, "_bottom"},  {7'd0, bottomLow},  8'((mData % 2 == 1) ? 0 : 1));
        check({tag, "_top"},     {7'd0, topLow},     8'((mData >= 128) ? 0 : 1));
    endtask

    task automatic bump();
        if (mMove < 255) mMove = mMove + 1;
    endtask

    // Apply one command for one clock edge, advance the model, compare everything.
    task automatic doCycle(input string tag, input logic c, input logic l0, input logic l1,
                           input logic [1:0] sh);
        clearLow = c;
        load0Low = l0;
        load1Low = l1;
        shiftSel = sh;
        @(posedge clk);
        #1;
        mAck = 1;
        mBlk = 1;
        if (!c) begin
            mData = 0; mMove = 0; mAck = 0;
        end else if (!l0) begin
            mData = 24; mAck = 0;
        end else if (!l1) begin
            mData = 1; mAck = 0;
        end else if (sh == 2'b01) begin
            mAck = 0;
            if (mData >= 128) begin
`ifdef SC_REGSHIFT_WRAP_EN
                mData = (mData * 2) % 256 + 1;
                bump();
`else
                mBlk = 0;
`endif
            end else begin
                mData = mData * 2;
                bump();
            end
        end else if (sh == 2'b10) begin
            mAck = 0;
            if (mData % 2 == 1) begin
`ifdef SC_REGSHIFT_WRAP_EN
                mData = mData / 2 + 128;
                bump();
`else
                mBlk = 0;
`endif
            end else begin
                mData = mData / 2;
                bump();
            end
        end
        checkAll(tag);
    endtask

    task automatic idle(input string tag);
        doCycle(tag, 1'b1, 1'b1, 1'b1, 2'b00);
    endtask

    initial begin
        clearLow = 1'b1;
        load0Low = 1'b1;
        load1Low = 1'b1;
        shiftSel = 2'b00;
        rst      = 1'b1;
        #3;
        checkAll("reset");
        #9;
        rst = 1'b0;

        // Load0 and single-cycle ack
        doCycle("load0", 1'b1, 1'b0, 1'b1, 2'b00);
        idle("load0_idle");

        // Three left shifts from 0x18
        doCycle("load0b", 1'b1, 1'b0, 1'b1, 2'b00);
        doCycle("shl1", 1'b1, 1'b1, 1'b1, 2'b01);
        doCycle("shl2", 1'b1, 1'b1, 1'b1, 2'b01);
        doCycle("shl3", 1'b1, 1'b1, 1'b1, 2'b01);
        check("shl3_value", dataOut, 8'hC0);
        idle("shl_idle");

        // Load1 then shift right at the bottom edge
        doCycle("load1", 1'b1, 1'b1, 1'b0, 2'b00);
        doCycle("shr_edge", 1'b1, 1'b1, 1'b1, 2'b10);
`ifdef SC_REGSHIFT_WRAP_EN
        check("shr_wrap_value", dataOut, 8'h80);
`else
        check("shr_block_value", dataOut, 8'h01);
`endif
        idle("shr_idle");

        // Hold codes 11 leave everything alone
        doCycle("hold11", 1'b1, 1'b1, 1'b1, 2'b11);

        // Simultaneous clear, load0 and shift
        doCycle("simul", 1'b0, 1'b0, 1'b1, 2'b01);
        check("simul_value", dataOut, 8'h00);
        idle("simul_idle");

        // Async reset between edges during a shift sequence
        doCycle("pre_rst_load", 1'b1, 1'b0, 1'b1, 2'b00);
        doCycle("pre_rst_shl", 1'b1, 1'b1, 1'b1, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        mData = 0; mMove = 0; mAck = 1; mBlk = 1;
        checkAll("async_rst");
        #1;
        rst = 1'b0;
        doCycle("post_rst_load1", 1'b1, 1'b1, 1'b0, 2'b00);
        check("post_rst_value", dataOut, 8'h01);

        // Shifting zero counts as a move; counter saturates at 255
        doCycle("sat_clear", 1'b0, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 260; i++) doCycle("sat_shift", 1'b1, 1'b1, 1'b1, 2'b10);
        check("sat_value", moveCount, 8'd255);

        // Long left-shift run from 0x18
        doCycle("long_clear", 1'b0, 1'b1, 1'b1, 2'b00);
        doCycle("long_load0", 1'b1, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 300; i++) doCycle("long_shl", 1'b1, 1'b1, 1'b1, 2'b01);
`ifdef SC_REGSHIFT_WRAP_EN
        check("long_move", moveCount, 8'd255);
        check("long_data", dataOut, 8'h81);
`else
        check("long_move", moveCount, 8'd3);
        check("long_data", dataOut, 8'hC0);
`endif

        // Random command mix against the model
        for (int i = 0; i < 400; i++) begin
            doCycle("rand",
                    ($urandom_range(0, 15) != 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) != 0),
                    2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
